// File: rtl/ptr_sync_gray.sv
// Multi-channel Gray-pointer synchroniser into the dest_clk domain, with binary
// conversion, per-cycle advance, update strobe and sticky illegal-jump detection.
module ptr_sync_gray #(
    parameter int ASIZE    = 4,
    parameter int STAGES   = 2,
    parameter int CHANNELS = 1
) (
    input  logic                            dest_clk,
    input  logic                            dest_rst_n,
    input  logic [CHANNELS*(ASIZE+1)-1:0]   src_ptr,
    input  logic [CHANNELS-1:0]             err_clr,
    output logic [CHANNELS*(ASIZE+1)-1:0]   dest_ptr,
    output logic [CHANNELS*(ASIZE+1)-1:0]   dest_bin,
    output logic [CHANNELS*(ASIZE+1)-1:0]   dest_delta,
    output logic [CHANNELS-1:0]             dest_upd,
    output logic [CHANNELS-1:0]             dest_err
);

    localparam int PW = ASIZE + 1;
    // Largest legal advance between two samples: exactly one full FIFO.
    localparam logic [PW-1:0] FULL_SPAN = {1'b1, {ASIZE{1'b0}}};

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            // Plain flop chain: nothing may sit between the source pointer and
            // the first flop, or between flops, for the Gray crossing to be safe.
            logic [STAGES-1:0][PW-1:0] sync_reg;
            logic [PW-1:0]             ptr_reg;
            logic [PW-1:0]             bin_reg;
            logic [PW-1:0]             delta_reg;
            logic                      upd_reg;
            logic                      err_reg;

            logic [PW-1:0]             arrive_gray;
            logic [PW-1:0]             arrive_bin;
            logic [PW-1:0]             delta_next;
            logic                      upd_next;
            logic                      viol;
            logic                      err_next;

            always_ff @(posedge dest_clk or negedge dest_rst_n) begin
                if (!dest_rst_n) begin
                    sync_reg <= '0;
                end else if (STAGES > 1) begin
                    sync_reg <= {sync_reg[STAGES-2:0], src_ptr[gi*PW +: PW]};
                end else begin
                    sync_reg[0] <= src_ptr[gi*PW +: PW];
                end
            end

            // Delta is taken against the registered binary, so after reset the
            // first arriving pointer is measured from zero.
            always_comb begin
                arrive_gray = sync_reg[STAGES-1];
                arrive_bin  = gray2bin(arrive_gray);
                delta_next  = arrive_bin - bin_reg;
                upd_next    = (delta_next != '0);
                viol        = (delta_next > FULL_SPAN);
                err_next    = viol | (err_reg & ~err_clr[gi]);
            end

            always_ff @(posedge dest_clk or negedge dest_rst_n) begin
                if (!dest_rst_n) begin
                    ptr_reg   <= '0;
                    bin_reg   <= '0;
                    delta_reg <= '0;
                    upd_reg   <= 1'b0;
                    err_reg   <= 1'b0;
                end else begin
                    ptr_reg   <= arrive_gray;
                    bin_reg   <= arrive_bin;
                    delta_reg <= delta_next;
                    upd_reg   <= upd_next;
                    err_reg   <= err_next;
                end
            end

            assign dest_ptr[gi*PW +: PW]   = ptr_reg;
            assign dest_bin[gi*PW +: PW]   = bin_reg;
            assign dest_delta[gi*PW +: PW] = delta_reg;
            assign dest_upd[gi]            = upd_reg;
            assign dest_err[gi]            = err_reg;
        end
    endgenerate

endmodule

// File: tb/tb_ptr_sync_gray.sv
// Bench for ptr_sync_gray (ASIZE=4, STAGES=2, CHANNELS=2): directed scenarios with
// literal expectations plus a per-cycle comparison against a delay-line model.
`timescale 1ns/1ps
module tb_ptr_sync_gray;

    localparam int ASIZE = 4;
    localparam int STG   = 2;
    localparam int CH    = 2;
    localparam int W     = ASIZE + 1;

    logic              dest_clk = 1'b0;
    logic              src_clk  = 1'b0;
    logic              dest_rst_n = 1'b0;
    logic [CH*W-1:0]   src_ptr = '0;
    logic [CH-1:0]     err_clr = '0;
    logic [CH*W-1:0]   dest_ptr, dest_bin, dest_delta;
    logic [CH-1:0]     dest_upd, dest_err;

    int tests_run = 0;
    int tests_failed = 0;

    ptr_sync_gray #(.ASIZE(ASIZE), .STAGES(STG), .CHANNELS(CH)) dut (
        .dest_clk   (dest_clk),
        .dest_rst_n (dest_rst_n),
        .src_ptr    (src_ptr),
        .err_clr    (err_clr),
        .dest_ptr   (dest_ptr),
        .dest_bin   (dest_bin),
        .dest_delta (dest_delta),
        .dest_upd   (dest_upd),
        .dest_err   (dest_err)
    );

    // dest : src period ratio 3 : 7
    always #3 dest_clk = ~dest_clk;
    always #7 src_clk  = ~src_clk;

    function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = '0;
        for (int i = 0; i < W; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: outputs reflect the source pointer seen STG edges earlier; delta is
    // the modular advance of that value, errors stick until an unopposed clear.
    logic [W-1:0] m_hist [CH][STG];
    logic [W-1:0] m_ptr  [CH];
    logic [W-1:0] m_bin  [CH];
    logic [W-1:0] m_delta[CH];
    logic         m_upd  [CH];
    logic         m_err  [CH];

    always @(posedge dest_clk or negedge dest_rst_n) begin
        if (!dest_rst_n) begin
            for (int c = 0; c < CH; c++) begin
                for (int s = 0; s < STG; s++) m_hist[c][s] <= '0;
                m_ptr[c] <= '0; m_bin[c] <= '0; m_delta[c] <= '0;
                m_upd[c] <= 1'b0; m_err[c] <= 1'b0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                m_hist[c][0] <= src_ptr[c*W +: W];
                for (int s = 1; s < STG; s++) m_hist[c][s] <= m_hist[c][s-1];
                m_ptr[c]   <= m_hist[c][STG-1];
                m_bin[c]   <= g2b(m_hist[c][STG-1]);
                m_delta[c] <= W'(g2b(m_hist[c][STG-1]) - m_bin[c]);
                m_upd[c]   <= (g2b(m_hist[c][STG-1]) != m_bin[c]);
                m_err[c]   <= (int'(W'(g2b(m_hist[c][STG-1]) - m_bin[c])) > (1 << ASIZE))
                              ? 1'b1 : (err_clr[c] ? 1'b0 : m_err[c]);
            end
        end
    end

    always @(negedge dest_clk) begin
        for (int c = 0; c < CH; c++) begin
            check($sformatf("ch%0d dest_ptr", c),   int'(dest_ptr[c*W +: W]),   int'(m_ptr[c]));
            check($sformatf("ch%0d dest_bin", c),   int'(dest_bin[c*W +: W]),   int'(m_bin[c]));
            check($sformatf("ch%0d dest_delta", c), int'(dest_delta[c*W +: W]), int'(m_delta[c]));
            check($sformatf("ch%0d dest_upd", c),   int'(dest_upd[c]),          int'(m_upd[c]));
            check($sformatf("ch%0d dest_err", c),   int'(dest_err[c]),          int'(m_err[c]));
        end
    end

    task automatic tick();
        @(posedge dest_clk);
        #1;
    endtask

    task automatic set_bin(input int c, input int b);
        src_ptr[c*W +: W] = b2g(W'(b));
    endtask

    task automatic chk_ch(input string tag, input int c, input int exp_bin,
                          input int exp_delta, input int exp_upd, input int exp_err);
        check({tag, " ptr"},   int'(dest_ptr[c*W +: W]),   int'(b2g(W'(exp_bin))));
        check({tag, " bin"},   int'(dest_bin[c*W +: W]),   exp_bin);
        check({tag, " delta"}, int'(dest_delta[c*W +: W]), exp_delta);
        check({tag, " upd"},   int'(dest_upd[c]),          exp_upd);
        check({tag, " err"},   int'(dest_err[c]),          exp_err);
    endtask

    int wrap_vals[3] = '{30, 31, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) tick();
        chk_ch("reset ch0", 0, 0, 0, 0, 0);
        chk_ch("reset ch1", 1, 0, 0, 0, 0);
        dest_rst_n = 1'b1;
        repeat (3) tick();
        chk_ch("idle ch0", 0, 0, 0, 0, 0);

        // Latency: 5'b00010 stable before edge k, visible after edge k+2
        src_ptr[W-1:0] = 5'b00010;
        tick();
        tick();
        check("lat k+1 bin", int'(dest_bin[W-1:0]), 0);
        tick();
        check("lat ptr", int'(dest_ptr[W-1:0]), 2);
        chk_ch("lat k+2", 0, 3, 3, 1, 0);
        tick();
        chk_ch("lat k+3", 0, 3, 0, 0, 0);

        // Walk ch0 up to 29, then 30, 31, 0 one step every 3 cycles
        for (int v = 4; v <= 29; v++) begin
            set_bin(0, v);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            set_bin(0, wrap_vals[i]);
            repeat (3) tick();
            chk_ch($sformatf("wrap to %0d", wrap_vals[i]), 0, wrap_vals[i], 1, 1, 0);
        end

        // Full-boundary jumps: 0 -> 16 -> 0
        src_ptr[W-1:0] = 5'b11000;
        repeat (3) tick();
        chk_ch("full 0->16", 0, 16, 16, 1, 0);
        set_bin(0, 0);
        repeat (3) tick();
        chk_ch("full 16->0", 0, 0, 16, 1, 0);

        // Illegal jump on ch1 only
        src_ptr[2*W-1:W] = 5'b11110;
        repeat (3) tick();
        chk_ch("err ch1 0->20", 1, 20, 20, 1, 1);
        check("err ch0 untouched", int'(dest_err[0]), 0);
        tick();
        check("err sticky", int'(dest_err[1]), 1);
        err_clr[1] = 1'b1;
        tick();
        err_clr[1] = 1'b0;
        check("err cleared", int'(dest_err[1]), 0);
        // 20 -> 5 is an advance of 17; clear lands on the same edge
        set_bin(1, 5);
        tick();
        tick();
        err_clr = 2'b11;
        tick();
        err_clr = 2'b00;
        chk_ch("set beats clear", 1, 5, 17, 1, 1);
        check("clear ch0 idle err", int'(dest_err[0]), 0);
        tick();
        check("err held after", int'(dest_err[1]), 1);
        err_clr[1] = 1'b1;
        tick();
        err_clr[1] = 1'b0;
        check("err cleared again", int'(dest_err[1]), 0);

        // Reset mid-operation with ch0 at 7 and ch1 at 5 held
        set_bin(0, 7);
        repeat (3) tick();
        chk_ch("pre-reset ch0", 0, 7, 7, 1, 0);
        tick();
        dest_rst_n = 1'b0;
        #1;
        chk_ch("in reset ch0", 0, 0, 0, 0, 0);
        chk_ch("in reset ch1", 1, 0, 0, 0, 0);
        tick();
        dest_rst_n = 1'b1;
        tick();
        tick();
        chk_ch("post-reset k+1", 0, 0, 0, 0, 0);
        tick();
        chk_ch("post-reset ch0", 0, 7, 7, 1, 0);
        chk_ch("post-reset ch1", 1, 5, 5, 1, 0);
        tick();
        chk_ch("post-reset after", 0, 7, 0, 0, 0);

        // Random legal single-step increments driven from the slower src clock
        for (int n = 0; n < 200; n++) begin
            @(posedge src_clk);
            #1;
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(1) == 1)
                    src_ptr[c*W +: W] = b2g(W'(g2b(src_ptr[c*W +: W]) + 1'b1));
            end
        end
        repeat (4) tick();
        for (int c = 0; c < CH; c++) begin
            check($sformatf("rand ch%0d final bin", c), int'(dest_bin[c*W +: W]),
                  int'(g2b(src_ptr[c*W +: W])));
            check($sformatf("rand ch%0d err", c), int'(dest_err[c]), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
